gate_sensor_decoder: RTL

//  Front end of the parking gate. Conditions two beam-break sensors: A is on the street side, B is on the lot side.

---
 rtl/gate_sensor_decoder_if.sv | 63 ++++++
 rtl/gate_sensor_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sensor_decoder_if.sv
// ---------------------------------------------------------------------------
// gate_sensor_decoder_if
// Groups the parking-gate sensor inputs and the decoder outputs into one
// bundle. Clock and reset stay plain ports on the decoder.
//
// Signals:
//   sensor_a   raw street-side beam, 1 = blocked (asynchronous)
//   sensor_b   raw lot-side beam, 1 = blocked (asynchronous)
//   lot_full   1 = no free spot
//   car_enter  one-cycle pulse per completed entry
//   car_exit   one-cycle pulse per completed exit
//   gate_open  level, barrier raised
//   fault      one-cycle pulse on sequence timeout
//   deny_cnt   (EVENT_STATS_EN only) saturating count of refused entries
//   fault_cnt  (EVENT_STATS_EN only) saturating count of fault pulses
//
// Modports:
//   master  sensor/occupancy side: drives sensors and lot_full
//   slave   the decoder: consumes sensors, drives the event outputs
//
// Optional feature macro: EVENT_STATS_EN
// ---------------------------------------------------------------------------
interface gate_sensor_decoder_if;
  logic       sensor_a;
  logic       sensor_b;
  logic       lot_full;
  logic       car_enter;
  logic       car_exit;
  logic       gate_open;
  logic       fault;
`ifdef EVENT_STATS_EN
  logic [7:0] deny_cnt;
  logic [7:0] fault_cnt;
`endif

  modport master (
    output sensor_a,
    output sensor_b,
    output lot_full,
    input  car_enter,
    input  car_exit,
    input  gate_open,
`ifdef EVENT_STATS_EN
    input  deny_cnt,
    input  fault_cnt,
`endif
    input  fault
  );

  modport slave (
    input  sensor_a,
    input  sensor_b,
    input  lot_full,
    output car_enter,
    output car_exit,
    output gate_open,
`ifdef EVENT_STATS_EN
    output deny_cnt,
    output fault_cnt,
`endif
    output fault
  );
endinterface

// File: rtl/gate_sensor_decoder.sv
// ---------------------------------------------------------------------------
// gate_sensor_decoder
// Front end of the parking gate. Synchronises and debounces two beam-break
// sensors (A street side, B lot side), decodes the crossing order into
// one-cycle car_enter / car_exit pulses, drives the barrier, refuses entry
// while the lot is full and flags sequences that stall in a non-idle state.
//
// Ports:
//   clk_in   system clock, all logic on posedge
//   reset_n  asynchronous active-low reset
//   bus      gate_sensor_decoder_if.slave (sensors, lot_full, event outputs)
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synced sensor must hold a new value
//   TIMEOUT_CYCLES   max cycles in a non-IDLE state without a state change
//   TMO_W            timeout counter width, >= clog2(TIMEOUT_CYCLES+1)
//
// Optional feature macro: EVENT_STATS_EN (adds deny_cnt / fault_cnt)
// ---------------------------------------------------------------------------
module gate_sensor_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int TMO_W           = 11
) (
  input logic                  clk_in,
  input logic                  reset_n,
  gate_sensor_decoder_if.slave bus
);

  localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    IN_A   = 4'd1,
    IN_AB  = 4'd2,
    IN_B   = 4'd3,
    OUT_B  = 4'd4,
    OUT_AB = 4'd5,
    OUT_A  = 4'd6,
    DENY   = 4'd7,
    CLEAR  = 4'd8
  } state_t;

  // Bit 1 carries sensor A, bit 0 sensor B, so filt_r reads as {a,b}.
  logic [1:0]       raw_s;
  logic [1:0]       meta_r;
  logic [1:0]       sync_r;
  logic [1:0]       filt_r;
  logic [DB_W-1:0]  db_cnt_r [2];

  state_t           state_r;
  state_t           state_nxt_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [TMO_W-1:0] tmo_nxt_s;
  logic             timeout_s;
  logic             enter_nxt_s;
  logic             exit_nxt_s;
  logic             gate_nxt_s;
  logic             deny_evt_s;

  logic             car_enter_r;
  logic             car_exit_r;
  logic             gate_open_r;
  logic             fault_r;

  assign raw_s = {bus.sensor_a, bus.sensor_b};

  // Two-flop synchronizer for both raw beams.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
    end else begin
      meta_r <= raw_s;
      sync_r <= meta_r;
    end
  end

  // Debounce: filtered value follows the synced value only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      filt_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] == filt_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          filt_r[i]   <= sync_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  // Next-state, pulse, gate and timeout-counter decode.
  always_comb begin
    state_nxt_s = state_r;
    enter_nxt_s = 1'b0;
    exit_nxt_s  = 1'b0;
    deny_evt_s  = 1'b0;
    gate_nxt_s  = 1'b0;
    tmo_nxt_s   = tmo_cnt_r;
    timeout_s   = (state_r != IDLE) && (tmo_cnt_r == TMO_MAX);

    // A timeout overrides whatever the sensors are doing this cycle.
    if (timeout_s) begin
      state_nxt_s = CLEAR;
    end else begin
      case (state_r)
        IDLE: begin
          case (filt_r)
            2'b10: begin
              // lot_full only matters at this decision point.
              if (bus.lot_full) begin
                state_nxt_s = DENY;
                deny_evt_s  = 1'b1;
              end else begin
                state_nxt_s = IN_A;
              end
            end
            2'b01:   state_nxt_s = OUT_B;
            2'b11:   state_nxt_s = CLEAR;
            default: state_nxt_s = IDLE;
          endcase
        end
        IN_A: begin
          case (filt_r)
            2'b11:   state_nxt_s = IN_AB;
            2'b00:   state_nxt_s = IDLE;
            default: state_nxt_s = state_r;
          endcase
        end
        IN_AB: begin
          case (filt_r)
            2'b01:   state_nxt_s = IN_B;
            2'b10:   state_nxt_s = IN_A;
            default: state_nxt_s = state_r;
          endcase
        end
        IN_B: begin
          case (filt_r)
            2'b00: begin
              state_nxt_s = IDLE;
              enter_nxt_s = 1'b1;
            end
            2'b11:   state_nxt_s = IN_AB;
            default: state_nxt_s = state_r;
          endcase
        end
        OUT_B: begin
          case (filt_r)
            2'b11:   state_nxt_s = OUT_AB;
            2'b00:   state_nxt_s = IDLE;
            default: state_nxt_s = state_r;
          endcase
        end
        OUT_AB: begin
          case (filt_r)
            2'b10:   state_nxt_s = OUT_A;
            2'b01:   state_nxt_s = OUT_B;
            default: state_nxt_s = state_r;
          endcase
        end
        OUT_A: begin
          case (filt_r)
            2'b00: begin
              state_nxt_s = IDLE;
              exit_nxt_s  = 1'b1;
            end
            2'b11:   state_nxt_s = OUT_AB;
            default: state_nxt_s = state_r;
          endcase
        end
        DENY, CLEAR: begin
          if (filt_r == 2'b00) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end

    case (state_nxt_s)
      IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A: gate_nxt_s = 1'b1;
      default:                                 gate_nxt_s = 1'b0;
    endcase

    // Clearing on timeout also restarts the count when already in CLEAR.
    if ((state_nxt_s != state_r) || (state_r == IDLE) || timeout_s) begin
      tmo_nxt_s = '0;
    end else if (tmo_cnt_r == TMO_MAX) begin
      tmo_nxt_s = tmo_cnt_r;
    end else begin
      tmo_nxt_s = tmo_cnt_r + TMO_W'(1);
    end
  end

  // FSM state, timeout counter and registered outputs.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      tmo_cnt_r   <= '0;
      car_enter_r <= 1'b0;
      car_exit_r  <= 1'b0;
      gate_open_r <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      tmo_cnt_r   <= tmo_nxt_s;
      car_enter_r <= enter_nxt_s;
      car_exit_r  <= exit_nxt_s;
      gate_open_r <= gate_nxt_s;
      fault_r     <= timeout_s;
    end
  end

  assign bus.car_enter = car_enter_r;
  assign bus.car_exit  = car_exit_r;
  assign bus.gate_open = gate_open_r;
  assign bus.fault     = fault_r;

`ifdef EVENT_STATS_EN
  logic [7:0] deny_cnt_r;
  logic [7:0] fault_cnt_r;

  // Saturating event counters for refused entries and timeouts.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      deny_cnt_r  <= 8'h00;
      fault_cnt_r <= 8'h00;
    end else begin
      if (deny_evt_s && (deny_cnt_r != 8'hFF)) begin
        deny_cnt_r <= deny_cnt_r + 8'h01;
      end
      if (timeout_s && (fault_cnt_r != 8'hFF)) begin
        fault_cnt_r <= fault_cnt_r + 8'h01;
      end
    end
  end

  assign bus.deny_cnt  = deny_cnt_r;
  assign bus.fault_cnt = fault_cnt_r;
`endif

endmodule
